// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline: boot address, bubble encoding,
// fetch FSM states and the IF/ID pipeline register payload.
package core_pkg;

  localparam logic [31:0] RESET_PC  = 32'hBFC00000;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. A flush turns the slot into a bubble (NOP, not
// valid) while keeping the PC fields; a stall holds everything. Flush wins.
module if_id_reg
  import core_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  // Register update with reset > flush > stall > capture priority
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
    end else if (flush) begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the combinational instruction ROM and loads
// the IF/ID register. Optional performance counters are built when the macro
// FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import core_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] RESET_PC      = core_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR     = core_pkg::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     StallF,
  input  logic                     StallD,
  input  logic                     FlushD,
  input  logic                     PCSrcE,
  input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
  input  logic                     HaltReq,
  input  logic [DATA_WIDTH-1:0]    InstrF,
  output logic [ADDRESS_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0]    InstrD,
  output logic [ADDRESS_WIDTH-1:0] PCD,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
  output logic                     ValidD,
  output logic                     Halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              FetchCount,
  output logic [31:0]              StallCount
`endif
);

  fetch_state_t             state;
  if_id_t                   if_id_next;
  if_id_t                   if_id_q;
  logic                     bubble;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic [ADDRESS_WIDTH-1:0] redirect_pc;

  assign pc_plus4    = PCF + ADDRESS_WIDTH'(4);
  assign redirect_pc = PCTargetE & ~ADDRESS_WIDTH'(3);
  assign bubble      = FlushD | PCSrcE | HaltReq | (state != RUN);
  assign if_id_next  = '{instr: InstrF, pc: PCF, pc_plus4: pc_plus4, valid: 1'b1};

  // Fetch FSM: one settle cycle after reset, then run until a halt request
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (HaltReq) state <= HALT;
        HALT:    state <= HALT;
        default: state <= BOOT;
      endcase
    end
  end

  // PC only moves while running; a redirect overrides a fetch stall
  always_ff @(posedge clk) begin
    if (rst) begin
      PCF <= ADDRESS_WIDTH'(RESET_PC);
    end else if (state == RUN) begin
      if (PCSrcE) begin
        PCF <= redirect_pc;
      end else if (!StallF) begin
        PCF <= pc_plus4;
      end
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk  (clk),
    .rst  (rst),
    .stall(StallD),
    .flush(bubble),
    .d    (if_id_next),
    .q    (if_id_q)
  );

  assign InstrD   = if_id_q.instr;
  assign PCD      = if_id_q.pc;
  assign PCPlus4D = if_id_q.pc_plus4;
  assign ValidD   = if_id_q.valid;
  assign Halted   = (state == HALT);

`ifdef FETCH_PERF_CNT_EN
  // Count real captures and fetch-stall cycles; both freeze outside RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else if (state == RUN) begin
      if (!bubble && !StallD) begin
        FetchCount <= FetchCount + 32'd1;
      end
      if (StallF && !PCSrcE) begin
        StallCount <= StallCount + 32'd1;
      end
    end
  end
`endif

endmodule
